// File: rtl/mips_dbg_pkg.sv
// Shared encodings for the MIPS debug/run-control logic.
// State values are visible on LEDs, so their numeric encoding is fixed.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RATE = 2'b01,
    MODE_FULL = 2'b10,
    MODE_STEP = 2'b11
  } run_mode_e;

  localparam int STEP_W  = 8;
  localparam int COUNT_W = 32;

  // A requested burst of zero cycles still performs one cycle.
  function automatic logic [STEP_W-1:0] step_load(input logic [STEP_W-1:0] n);
    return (n == '0) ? STEP_W'(1) : n;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for already-debounced button levels.
// The history flop resets to 1 so a button held through reset gives no pulse.
module edge_pulse (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic history;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      history <= 1'b1;
    end else begin
      history <= level;
    end
  end

  assign pulse = level & ~history;

endmodule

// File: rtl/run_controller.sv
// Run controller for the MIPS core: produces a clock-enable for halt, rate-run,
// full-run and N-cycle stepping, with PC breakpoints and an enabled-cycle counter.
module run_controller
  import mips_dbg_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int NUM_BP = 2,
  parameter int DIV_W  = 26
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   step_req,
  input  logic [STEP_W-1:0]      step_count,
  input  logic [DIV_W-1:0]       rate_div,
  input  logic                   resume,
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   core_en,
  output logic                   halted,
  output logic [NUM_BP-1:0]      bp_hit,
  output logic [COUNT_W-1:0]     cycle_count,
  output logic [1:0]             state
);

  run_state_e        cur_state;
  run_state_e        nxt_state;
  logic [DIV_W-1:0]  divider;
  logic [DIV_W-1:0]  divider_nxt;
  logic [STEP_W-1:0] step_remaining;
  logic [STEP_W-1:0] step_remaining_nxt;
  logic [NUM_BP-1:0] bp_hit_nxt;
  logic [NUM_BP-1:0] slot_hit;
  logic              skip;
  logic              skip_nxt;
  logic              match;
  logic              tick;
  logic              rate_every;
  logic              step_pulse;
  logic              resume_pulse;

  edge_pulse u_step_edge (
    .clock (clock),
    .reset (reset),
    .level (step_req),
    .pulse (step_pulse)
  );

  edge_pulse u_resume_edge (
    .clock (clock),
    .reset (reset),
    .level (resume),
    .pulse (resume_pulse)
  );

  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    assign slot_hit[i] = bp_en[i] & (pc == bp_addr[i*PC_W +: PC_W]);
  end

  // skip lets the core execute the instruction at the breakpoint it just resumed from.
  assign match = (|slot_hit) & ~skip;

  assign rate_every = (rate_div < DIV_W'(2));

  always_comb begin
    tick = 1'b0;
    if (mode == MODE_FULL) begin
      tick = 1'b1;
    end else if (mode == MODE_RATE) begin
      tick = rate_every || (divider == rate_div - DIV_W'(1));
    end
  end

  always_comb begin
    nxt_state          = cur_state;
    core_en            = 1'b0;
    divider_nxt        = divider;
    step_remaining_nxt = step_remaining;
    bp_hit_nxt         = bp_hit;
    skip_nxt           = skip;

    case (cur_state)
      ST_HALT: begin
        if (mode == MODE_RATE || mode == MODE_FULL) begin
          nxt_state   = ST_RUN;
          divider_nxt = '0;
        end else if (mode == MODE_STEP && step_pulse) begin
          nxt_state          = ST_STEP;
          step_remaining_nxt = step_load(step_count);
        end
      end

      ST_RUN: begin
        if (mode == MODE_HALT || mode == MODE_STEP) begin
          nxt_state = ST_HALT;
        end else if (tick) begin
          divider_nxt = '0;
          if (match) begin
            nxt_state  = ST_BREAK;
            bp_hit_nxt = bp_hit | slot_hit;
          end else begin
            core_en = 1'b1;
          end
        end else begin
          divider_nxt = divider + DIV_W'(1);
        end
      end

      ST_STEP: begin
        if (mode != MODE_STEP) begin
          nxt_state          = ST_HALT;
          step_remaining_nxt = '0;
        end else if (match) begin
          nxt_state          = ST_BREAK;
          step_remaining_nxt = '0;
          bp_hit_nxt         = bp_hit | slot_hit;
        end else if (step_remaining != '0) begin
          core_en            = 1'b1;
          step_remaining_nxt = step_remaining - STEP_W'(1);
          if (step_remaining == STEP_W'(1)) begin
            nxt_state = ST_HALT;
          end
        end else begin
          nxt_state = ST_HALT;
        end
      end

      ST_BREAK: begin
        if (resume_pulse) begin
          nxt_state  = ST_HALT;
          bp_hit_nxt = '0;
          skip_nxt   = 1'b1;
        end
      end

      default: begin
        nxt_state = ST_HALT;
      end
    endcase

    if (core_en) begin
      skip_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_state      <= ST_HALT;
      divider        <= '0;
      step_remaining <= '0;
      bp_hit         <= '0;
      skip           <= 1'b0;
    end else begin
      cur_state      <= nxt_state;
      divider        <= divider_nxt;
      step_remaining <= step_remaining_nxt;
      bp_hit         <= bp_hit_nxt;
      skip           <= skip_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (core_en) begin
      cycle_count <= cycle_count + COUNT_W'(1);
    end
  end

  assign halted = (cur_state == ST_HALT) || (cur_state == ST_BREAK);
  assign state  = cur_state;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed scenarios plus randomized
// rate, step-length and breakpoint cases checked against arithmetic expectations.
module tb_run_controller;
  import mips_dbg_pkg::*;

  localparam int PC_W   = 16;
  localparam int NUM_BP = 2;
  localparam int DIV_W  = 26;

  logic                   clock;
  logic                   reset;
  logic [1:0]             mode;
  logic                   step_req;
  logic [7:0]             step_count;
  logic [DIV_W-1:0]       rate_div;
  logic                   resume;
  logic [PC_W-1:0]        pc;
  logic [NUM_BP*PC_W-1:0] bp_addr;
  logic [NUM_BP-1:0]      bp_en;
  logic                   core_en;
  logic                   halted;
  logic [NUM_BP-1:0]      bp_hit;
  logic [31:0]            cycle_count;
  logic [1:0]             state;

  int          checks;
  int          errors;
  int          seen_en;
  logic        last_en;
  logic [31:0] exp_cycles;

  run_controller #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP),
    .DIV_W  (DIV_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mode        (mode),
    .step_req    (step_req),
    .step_count  (step_count),
    .rate_div    (rate_div),
    .resume      (resume),
    .pc          (pc),
    .bp_addr     (bp_addr),
    .bp_en       (bp_en),
    .core_en     (core_en),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .cycle_count (cycle_count),
    .state       (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference expectations derived from the run rules, not from the FSM.
  function automatic int model_rate(input int n, input int r);
    return (r <= 1) ? n : n / r;
  endfunction

  function automatic int model_step(input int sc);
    return (sc == 0) ? 1 : sc;
  endfunction

  function automatic int model_bp_cycles(input int addr);
    return addr / 4;
  endfunction

  // One clock: observe core_en mid-cycle, then advance the PC model if the core ran.
  task automatic clk_cycle();
    @(negedge clock);
    last_en = core_en;
    if (core_en) seen_en++;
    @(posedge clock);
    #1;
    if (last_en) pc = pc + 16'd4;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    mode       = 2'b11;
    step_req   = 1'b1;
    step_count = 8'd0;
    rate_div   = '0;
    resume     = 1'b0;
    pc         = '0;
    bp_addr    = '0;
    bp_en      = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    exp_cycles = 0;
    seen_en    = 0;
    repeat (4) clk_cycle();
    checks++;
    if (seen_en !== 0) begin
      errors++;
      $display("[TB] FAIL reset_no_step: got %0d enables, want 0", seen_en);
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_halted: got %b, want 1", halted);
    end
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %0d, want 0", state);
    end
    checks++;
    if (cycle_count !== 32'd0 || bp_hit !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_regs: count %0d hit %b, want 0 00", cycle_count, bp_hit);
    end
    step_req = 1'b0;
    mode     = 2'b00;
    clk_cycle();
  endtask

  task automatic test_full_run();
    int bad;
    bad     = 0;
    seen_en = 0;
    mode    = 2'b10;
    for (int i = 0; i < 101; i++) begin
      clk_cycle();
      if (last_en !== (i > 0)) bad++;
    end
    exp_cycles += 100;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL full_run_pattern: got %0d wrong cycles, want 0", bad);
    end
    checks++;
    if (cycle_count !== exp_cycles) begin
      errors++;
      $display("[TB] FAIL full_run_count: got %0d, want %0d", cycle_count, exp_cycles);
    end
    mode    = 2'b00;
    seen_en = 0;
    clk_cycle();
    checks++;
    if (last_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_stop_en: got %b, want 0", last_en);
    end
    repeat (4) clk_cycle();
    checks++;
    if (seen_en !== 0 || cycle_count !== exp_cycles || state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL full_stop_frozen: en %0d count %0d state %0d, want 0 %0d 0",
               seen_en, cycle_count, state, exp_cycles);
    end
  endtask

  task automatic test_rate_run();
    int bad;
    int r;
    int n;
    int exp;
    rate_div = DIV_W'(4);
    mode     = 2'b01;
    clk_cycle();
    bad     = 0;
    seen_en = 0;
    for (int i = 0; i < 40; i++) begin
      clk_cycle();
      if (last_en !== ((i % 4) == 3)) bad++;
    end
    exp_cycles += 10;
    checks++;
    if (seen_en !== 10) begin
      errors++;
      $display("[TB] FAIL rate4_count: got %0d enables, want 10", seen_en);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL rate4_pattern: got %0d wrong cycles, want 0", bad);
    end
    mode = 2'b00;
    clk_cycle();
    for (int k = 0; k < 5; k++) begin
      r = (k == 0) ? 0 : int'($urandom_range(1, 9));
      n = int'($urandom_range(8, 60));
      rate_div = DIV_W'(r);
      mode     = 2'b01;
      clk_cycle();
      seen_en = 0;
      repeat (n) clk_cycle();
      mode = 2'b00;
      clk_cycle();
      exp = model_rate(n, r);
      exp_cycles += 32'(exp);
      checks++;
      if (seen_en !== exp) begin
        errors++;
        $display("[TB] FAIL rate_rand: div %0d len %0d got %0d enables, want %0d", r, n, seen_en, exp);
      end
    end
    checks++;
    if (cycle_count !== exp_cycles) begin
      errors++;
      $display("[TB] FAIL rate_total: got %0d, want %0d", cycle_count, exp_cycles);
    end
  endtask

  task automatic test_step();
    int bad;
    int sc;
    int exp;
    mode       = 2'b11;
    step_count = 8'd3;
    step_req   = 1'b0;
    clk_cycle();
    bad      = 0;
    seen_en  = 0;
    step_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clk_cycle();
      if (last_en !== (i >= 1 && i <= 3)) bad++;
      if (i == 1) step_req = 1'b0;
      if (i == 2) step_req = 1'b1;
    end
    exp_cycles += 3;
    checks++;
    if (bad !== 0 || seen_en !== 3) begin
      errors++;
      $display("[TB] FAIL step3_burst: %0d enables %0d wrong cycles, want 3 0", seen_en, bad);
    end
    checks++;
    if (state !== 2'd0 || cycle_count !== exp_cycles) begin
      errors++;
      $display("[TB] FAIL step3_end: state %0d count %0d, want 0 %0d", state, cycle_count, exp_cycles);
    end
    for (int k = 0; k < 4; k++) begin
      sc = (k == 0) ? 0 : int'($urandom_range(0, 20));
      step_count = 8'(sc);
      step_req   = 1'b0;
      clk_cycle();
      seen_en  = 0;
      step_req = 1'b1;
      repeat (sc + 4) clk_cycle();
      exp = model_step(sc);
      exp_cycles += 32'(exp);
      checks++;
      if (seen_en !== exp) begin
        errors++;
        $display("[TB] FAIL step_len: count %0d got %0d enables, want %0d", sc, seen_en, exp);
      end
    end
    step_req = 1'b0;
    mode     = 2'b00;
    clk_cycle();
    checks++;
    if (cycle_count !== exp_cycles) begin
      errors++;
      $display("[TB] FAIL step_total: got %0d, want %0d", cycle_count, exp_cycles);
    end
  endtask

  task automatic test_breakpoint();
    int waited;
    int addr;
    int exp;
    mode    = 2'b00;
    pc      = '0;
    bp_addr = {16'hFFF0, 16'h0010};
    bp_en   = 2'b01;
    clk_cycle();
    seen_en = 0;
    waited  = 0;
    mode    = 2'b10;
    while (state !== 2'd3 && waited < 30) begin
      clk_cycle();
      waited++;
    end
    exp_cycles += 4;
    checks++;
    if (state !== 2'd3) begin
      errors++;
      $display("[TB] FAIL bp_reach: state %0d, want 3", state);
    end
    checks++;
    if (seen_en !== 4 || cycle_count !== exp_cycles || pc !== 16'h0010) begin
      errors++;
      $display("[TB] FAIL bp_stop: en %0d count %0d pc %h, want 4 %0d 0010", seen_en, cycle_count, pc, exp_cycles);
    end
    checks++;
    if (bp_hit !== 2'b01 || core_en !== 1'b0 || halted !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_flags: hit %b en %b halted %b, want 01 0 1", bp_hit, core_en, halted);
    end
    mode = 2'b00;
    repeat (3) clk_cycle();
    checks++;
    if (state !== 2'd3) begin
      errors++;
      $display("[TB] FAIL bp_hold: state %0d, want 3", state);
    end
    mode   = 2'b10;
    resume = 1'b1;
    clk_cycle();
    checks++;
    if (state !== 2'd0 || bp_hit !== 2'b00) begin
      errors++;
      $display("[TB] FAIL bp_resume: state %0d hit %b, want 0 00", state, bp_hit);
    end
    seen_en = 0;
    waited  = 0;
    while (pc !== 16'h0014 && waited < 10) begin
      clk_cycle();
      waited++;
    end
    mode = 2'b00;
    clk_cycle();
    resume = 1'b0;
    exp_cycles += 1;
    checks++;
    if (pc !== 16'h0014 || seen_en !== 1) begin
      errors++;
      $display("[TB] FAIL bp_skip_past: pc %h en %0d, want 0014 1", pc, seen_en);
    end
    for (int k = 0; k < 3; k++) begin
      addr    = 4 * int'($urandom_range(2, 12));
      pc      = '0;
      bp_addr = {16'(addr), 16'hFFF0};
      bp_en   = 2'b10;
      clk_cycle();
      seen_en = 0;
      waited  = 0;
      mode    = 2'b10;
      while (state !== 2'd3 && waited < 60) begin
        clk_cycle();
        waited++;
      end
      exp = model_bp_cycles(addr);
      exp_cycles += 32'(exp);
      checks++;
      if (seen_en !== exp || bp_hit !== 2'b10 || state !== 2'd3) begin
        errors++;
        $display("[TB] FAIL bp_rand: addr %h en %0d hit %b state %0d, want %0d 10 3",
                 addr, seen_en, bp_hit, state, exp);
      end
      mode   = 2'b00;
      resume = 1'b1;
      clk_cycle();
      resume = 1'b0;
      clk_cycle();
    end
    bp_en = '0;
    checks++;
    if (cycle_count !== exp_cycles) begin
      errors++;
      $display("[TB] FAIL bp_total: got %0d, want %0d", cycle_count, exp_cycles);
    end
  endtask

  task automatic test_reset_mid_step();
    mode       = 2'b11;
    step_count = 8'd10;
    step_req   = 1'b0;
    clk_cycle();
    step_req = 1'b1;
    clk_cycle();
    repeat (5) clk_cycle();
    reset = 1'b0;
    #1;
    checks++;
    if (core_en !== 1'b0 || state !== 2'd0 || cycle_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rst_async: en %b state %0d count %0d, want 0 0 0", core_en, state, cycle_count);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    exp_cycles = 0;
    seen_en    = 0;
    repeat (3) clk_cycle();
    checks++;
    if (seen_en !== 0 || state !== 2'd0 || cycle_count !== exp_cycles) begin
      errors++;
      $display("[TB] FAIL rst_release: en %0d state %0d count %0d, want 0 0 0", seen_en, state, cycle_count);
    end
    step_req = 1'b0;
    mode     = 2'b00;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    seen_en    = 0;
    last_en    = 1'b0;
    exp_cycles = 0;
    test_reset();
    test_full_run();
    test_rate_run();
    test_step();
    test_breakpoint();
    test_reset_mid_step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Parametrised successor to the manual/system clock-select logic in the MIPS pipeline top level.
- Runs from the single fast clock. Instead of muxing clocks, it produces a clock-enable (core_en) that qualifies every pipeline register, PC/cycle counter, register file and memory write.
- Run modes: halt, rate-divided run, full-speed run, and N-cycle single-step.
- Adds PC breakpoints with sticky hit reporting, plus an enabled-cycle counter for the UI.

Parameters:
- PC_W, 16, width of the program counter compared against breakpoints.
- NUM_BP, 2, number of breakpoint comparators.
- DIV_W, 26, width of the rate divider. Must cover 50 MHz to 1 Hz.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-low reset.
- mode  in  2  00 halt, 01 rate-run, 10 full-run, 11 step.
- step_req  in  1  debounced step button (level). Rising edge detected internally.
- step_count  in  8  enabled cycles per step request. 0 is treated as 1.
- rate_div  in  DIV_W  clocks per enable in rate-run. 0 and 1 both mean every cycle.
- resume  in  1  debounced resume button (level). Rising edge detected internally.
- pc  in  PC_W  current core PC.
- bp_addr  in  NUM_BP*PC_W  breakpoint addresses; slot i occupies bits [i*PC_W +: PC_W].
- bp_en  in  NUM_BP  per-slot breakpoint enable.
- core_en  out  1  core advances on clock edges where this is high.
- halted  out  1  high in HALT or BREAK.
- bp_hit  out  NUM_BP  sticky per-slot breakpoint hit flags.
- cycle_count  out  32  count of enabled cycles.
- state  out  2  current FSM state, for LEDs.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to HALT.
  - bp_hit = 0, cycle_count = 0, divider = 0, step_remaining = 0, skip = 0.
  - Both edge-detect history flops are set to 1, so a button held through reset generates no pulse.
  - core_en goes low immediately, because it is a function of the reset registers.
- core_en is combinational from registered state plus the pc comparison (one logic level). There is no added latency, so a breakpoint blocks the cycle in which pc already equals bp_addr.
- match = OR over i of (bp_en[i] & pc == bp_addr[i]) & ~skip.
- FSM states: HALT = 0, RUN = 1, STEP = 2, BREAK = 3.
- HALT:
  - core_en = 0.
  - mode 01 or 10: go to RUN next cycle.
  - mode 11 with a step edge: go to STEP, step_remaining = max(step_count, 1).
  - Step edges seen in any other mode are discarded.
- RUN:
  - tick = 1 every cycle in mode 10.
  - In mode 01, tick = 1 when divider == rate_div-1. The divider then wraps to 0; otherwise it increments. The divider clears on entry to RUN.
  - core_en = tick & ~match.
  - tick & match: go to BREAK, set bp_hit[i] for each matching slot.
  - mode 00 or 11: go to HALT. This takes priority over tick in the same cycle; core_en = 0.
- STEP:
  - core_en = ~match while step_remaining > 0. Each enabled cycle decrements step_remaining.
  - Go to HALT after the final enabled cycle (remaining 1 -> 0).
  - Step edges during STEP are ignored.
  - match: go to BREAK, step_remaining = 0.
  - mode != 11: abort to HALT, step_remaining = 0.
- BREAK:
  - core_en = 0, halted = 1.
  - A resume edge clears bp_hit, sets skip = 1 and goes to HALT.
  - Otherwise BREAK holds regardless of mode.
- skip:
  - Suppresses match until the next core_en cycle, then clears.
  - This lets the core execute past the breakpoint address.
- cycle_count increments on every core_en cycle and wraps 2^32-1 -> 0.
- A resume edge outside BREAK has no effect.
- A mid-operation mode or rate_div change takes effect the next cycle. A new rate_div below the current divider value wraps at 2^DIV_W (documented, not guarded).

Decomposition:
- Shared package mips_dbg_pkg holds:
  - state encodings ST_HALT, ST_RUN, ST_STEP, ST_BREAK;
  - mode encodings MODE_HALT, MODE_RATE, MODE_FULL, MODE_STEP.
- One sub-module, edge_pulse: single-flop rising-edge detector with a reset-to-1 history flop. Instantiated twice (step, resume).
- The breakpoint compare is a generate loop inside run_controller.

Test Plan:
- Hold step_req = 1 through reset, release reset with mode = 11 -> no core_en, halted = 1, state = 0.
- Mode 10 for 100 cycles -> core_en high from the cycle after mode is applied; cycle_count = 100. Set mode 00 -> core_en low next cycle, count frozen.
- Mode 01, rate_div = 4 -> core_en high on 1 cycle in 4 over 40 cycles; cycle_count = 10.
- Mode 11, step_count = 3, one step edge -> exactly 3 consecutive core_en, cycle_count = 3, then HALT. A step edge mid-burst is ignored. step_count = 0 -> exactly 1 core_en.
- Breakpoint: bp_en = 01, bp_addr[0] = 0x0010, mode 10, pc model adds 4 per core_en from 0 -> core_en low when pc = 0x0010, bp_hit = 01, state = 3, cycle_count = 4. Resume edge -> bp_hit = 00, HALT; run resumes and pc reaches 0x0014.
- Assert reset mid-STEP with step_remaining = 5 -> core_en low immediately; after release, state = HALT and cycle_count = 0.
